// File: rtl/mem_stage_seq_ctrl_pkg.sv
// Shared opcode/sub-code constants and FSM state type for the memory-stage sequencer.
package mem_stage_pkg;

   localparam logic [3:0] OP_STACK = 4'd7;
   localparam logic [3:0] OP_CTRL  = 4'd11;
   localparam logic [3:0] OP_LDST  = 4'd12;
   localparam logic [3:0] OP_LDI   = 4'd13;
   localparam logic [3:0] OP_STI   = 4'd14;

   localparam logic [1:0] RA_PUSH = 2'd0;
   localparam logic [1:0] RA_POP  = 2'd1;
   localparam logic [1:0] RA_CALL = 2'd1;
   localparam logic [1:0] RA_RET  = 2'd2;
   localparam logic [1:0] RA_RTI  = 2'd3;
   localparam logic [1:0] RA_LDD  = 2'd1;
   localparam logic [1:0] RA_STD  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_INT,
      S_RETIRE
   } state_t;

endpackage

// File: rtl/mem_stage_seq_ctrl_if.sv
// Pipeline/data-memory handshake bundle for the memory-stage sequencer.
interface mem_stage_seq_ctrl_if #(
   parameter int unsigned IDX_W = 1
);
   logic             valid_in;
   logic [7:0]       ir;
   logic             in_ready;
   logic             int_req;
   logic             mem_ready;
   logic             wm;
   logic             rm;
   logic             sm2;
   logic             done;
   logic             int_ack;
   logic [IDX_W-1:0] int_idx;
   logic             busy;
   logic             bus_err;

   modport master (
      output valid_in, ir, int_req, mem_ready,
      input  in_ready, wm, rm, sm2, done, int_ack, int_idx, busy, bus_err
   );

   modport slave (
      input  valid_in, ir, int_req, mem_ready,
      output in_ready, wm, rm, sm2, done, int_ack, int_idx, busy, bus_err
   );
endinterface

// File: rtl/mem_stage_seq_ctrl_mem_op_decode.sv
// Combinational classification of an instruction into memory write/read/non-memory.
module mem_op_decode
   import mem_stage_pkg::*;
(
   input  logic [7:0] ir,
   output logic       is_wr,
   output logic       is_rd,
   output logic       sel_mem
);
   logic [3:0] op;
   logic [1:0] ra;
   logic       unused_rb;

   assign op        = ir[7:4];
   assign ra        = ir[3:2];
   assign unused_rb = ^ir[1:0];

   always_comb begin
      is_wr = 1'b0;
      is_rd = 1'b0;
      case (op)
         OP_STACK: begin
            is_wr = (ra == RA_PUSH);
            is_rd = (ra == RA_POP);
         end
         OP_CTRL: begin
            is_wr = (ra == RA_CALL);
            is_rd = (ra == RA_RET) || (ra == RA_RTI);
         end
         OP_LDST: begin
            is_wr = (ra == RA_STD);
            is_rd = (ra == RA_LDD);
         end
         OP_LDI:  is_rd = 1'b1;
         OP_STI:  is_wr = 1'b1;
         default: ;
      endcase
   end

   assign sel_mem = is_rd;
endmodule

// File: rtl/mem_stage_seq_ctrl.sv
// Handshaked memory-stage sequencer: multi-cycle data accesses and interrupt-entry push.
// Optional wait-timeout abort is compiled in with MEM_TIMEOUT_EN.
module mem_stage_seq_ctrl
   import mem_stage_pkg::*;
#(
   parameter int unsigned INT_WORDS   = 2,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned IDX_W       = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mem_stage_seq_ctrl_if.slave  bus
);
   state_t           state_q, state_d;
   logic [7:0]       ir_q;
   logic [IDX_W-1:0] int_idx_q;
   logic             int_ack_q;
   logic             timeout_hit;
   logic             last_word;

   logic in_wr, in_rd, unused_in_sel;
   logic q_wr, q_rd, q_sel;

   // The incoming ir picks ACCESS vs RETIRE; the latched ir_q drives the strobes.
   mem_op_decode u_dec_in (
      .ir      (bus.ir),
      .is_wr   (in_wr),
      .is_rd   (in_rd),
      .sel_mem (unused_in_sel)
   );

   mem_op_decode u_dec_q (
      .ir      (ir_q),
      .is_wr   (q_wr),
      .is_rd   (q_rd),
      .sel_mem (q_sel)
   );

   assign last_word = (int_idx_q == IDX_W'(INT_WORDS - 1));

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] wait_q;
   logic             waiting;
   logic             bus_err_q;

   assign waiting     = ((state_q == S_ACCESS) || (state_q == S_INT)) && !bus.mem_ready;
   // A mem_ready arriving on the final allowed cycle clears waiting, so it beats the abort.
   assign timeout_hit = waiting && (wait_q == CNT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         wait_q    <= (waiting && !timeout_hit) ? wait_q + 1'b1 : '0;
         bus_err_q <= timeout_hit;
      end
   end

   assign bus.bus_err = bus_err_q;
`else
   logic unused_cfg;

   assign unused_cfg  = ^MEM_TIMEOUT;
   assign timeout_hit = 1'b0;
   assign bus.bus_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         int_idx_q <= '0;
         int_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         int_ack_q <= (state_q == S_INT) && bus.mem_ready && last_word;
         if ((state_q == S_IDLE) && !bus.int_req && bus.valid_in)
            ir_q <= bus.ir;
         if (state_d != S_INT)
            int_idx_q <= '0;
         else if ((state_q == S_INT) && bus.mem_ready)
            int_idx_q <= int_idx_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.int_req)
               state_d = S_INT;
            else if (bus.valid_in)
               state_d = (in_wr || in_rd) ? S_ACCESS : S_RETIRE;
         end
         S_ACCESS: begin
            if (bus.mem_ready)
               state_d = S_RETIRE;
            else if (timeout_hit)
               state_d = S_IDLE;
         end
         S_INT: begin
            if ((bus.mem_ready && last_word) || timeout_hit)
               state_d = S_IDLE;
         end
         S_RETIRE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready = (state_q == S_IDLE) && !bus.int_req;
      bus.busy     = (state_q != S_IDLE);
      bus.wm       = ((state_q == S_ACCESS) && q_wr) || (state_q == S_INT);
      bus.rm       = (state_q == S_ACCESS) && q_rd;
      bus.sm2      = ((state_q == S_ACCESS) || (state_q == S_RETIRE)) && q_sel;
      bus.done     = (state_q == S_RETIRE);
      bus.int_ack  = int_ack_q;
      bus.int_idx  = int_idx_q;
   end
endmodule

// File: tb/tb_mem_stage_seq_ctrl.sv
// Directed table-driven bench for mem_stage_seq_ctrl, plus timeout/boundary sequences.
module tb_mem_stage_seq_ctrl;
   localparam int unsigned IDX_W = 1;

   typedef struct packed {
      logic       in_ready;
      logic       wm;
      logic       rm;
      logic       sm2;
      logic       done;
      logic       int_ack;
      logic       busy;
      logic       bus_err;
      logic [0:0] int_idx;
   } out_t;

   typedef struct packed {
      logic       rst_n;
      logic       valid_in;
      logic [7:0] ir;
      logic       int_req;
      logic       mem_ready;
      out_t       exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   mem_stage_seq_ctrl_if #(.IDX_W(IDX_W)) bus ();

   mem_stage_seq_ctrl #(
      .INT_WORDS   (2),
      .MEM_TIMEOUT (15),
      .IDX_W       (IDX_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic out_t E(logic inr, logic wm, logic rm, logic sm2, logic done,
                              logic ack, logic busy, logic err, logic idx);
      out_t o;
      o = '{in_ready: inr, wm: wm, rm: rm, sm2: sm2, done: done,
            int_ack: ack, busy: busy, bus_err: err, int_idx: idx};
      return o;
   endfunction

   function automatic out_t sample();
      return E(bus.in_ready, bus.wm, bus.rm, bus.sm2, bus.done,
               bus.int_ack, bus.busy, bus.bus_err, bus.int_idx[0]);
   endfunction

   task automatic add(logic r, logic v, logic [7:0] ir, logic irq, logic mr,
                      logic inr, logic wm, logic rm, logic sm2, logic done,
                      logic ack, logic busy, logic idx);
      vec_t t;
      t.rst_n = r; t.valid_in = v; t.ir = ir; t.int_req = irq; t.mem_ready = mr;
      t.exp = E(inr, wm, rm, sm2, done, ack, busy, 1'b0, idx);
      vecs.push_back(t);
   endtask

   task automatic drive(logic v, logic [7:0] ir, logic irq, logic mr);
      bus.valid_in  = v;
      bus.ir        = ir;
      bus.int_req   = irq;
      bus.mem_ready = mr;
   endtask

   task automatic chk(string name, out_t act, out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {inr,wm,rm,sm2,done,ack,busy,err,idx}=%b required %b",
                  name, act, exp);
      end
   endtask

   // Check the current cycle's outputs, then advance past the next rising edge.
   task automatic cyc(string name, out_t exp);
      @(negedge clk);
      chk(name, sample(), exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      //  rst v  ir    irq mr   inr wm rm sm2 dn ack bsy idx
      add(0, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0); // reset state
      // PUSH, 3 wait cycles then ready
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 1, 8'h70, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 0,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 1,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   0,  0, 0, 0,  1, 0,  1,  0);
      add(1, 0, 8'h00, 0, 1,   1,  0, 0, 0,  0, 0,  0,  0); // mem_ready in IDLE ignored
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // LDI, immediate ready
      add(1, 1, 8'hD0, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 1,   0,  0, 1, 1,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 1,   0,  0, 0, 1,  1, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // ALU op; RETIRE refuses a new ir
      add(1, 1, 8'h20, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 1, 8'h70, 0, 0,   0,  0, 0, 0,  1, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // interrupt beats valid_in, two-word push
      add(1, 1, 8'h70, 1, 0,   0,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 0,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 1,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 1, 0,   0,  1, 0, 0,  0, 0,  1,  1);
      add(1, 0, 8'h00, 1, 1,   0,  1, 0, 0,  0, 0,  1,  1);
      add(1, 1, 8'h70, 0, 0,   1,  0, 0, 0,  0, 1,  0,  0);
      add(1, 0, 8'h00, 0, 1,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   0,  0, 0, 0,  1, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // STD aborted by reset mid-access
      add(1, 1, 8'hC8, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 0,   0,  1, 0, 0,  0, 0,  1,  0);
      add(0, 0, 8'h00, 0, 0,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // reset mid-interrupt
      add(1, 0, 8'h00, 1, 0,   0,  0, 0, 0,  0, 0,  0,  0);
      add(0, 0, 8'h00, 0, 0,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // op 11 ra=0 is non-memory
      add(1, 1, 8'hB0, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 0,   0,  0, 0, 0,  1, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // RET reads
      add(1, 1, 8'hB8, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 1,   0,  0, 1, 1,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   0,  0, 0, 1,  1, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      // STI writes
      add(1, 1, 8'hE5, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);
      add(1, 0, 8'h00, 0, 1,   0,  1, 0, 0,  0, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   0,  0, 0, 0,  1, 0,  1,  0);
      add(1, 0, 8'h00, 0, 0,   1,  0, 0, 0,  0, 0,  0,  0);

      foreach (vecs[i]) begin
         rst_n = vecs[i].rst_n;
         drive(vecs[i].valid_in, vecs[i].ir, vecs[i].int_req, vecs[i].mem_ready);
         cyc($sformatf("vec%0d", i), vecs[i].exp);
      end

      // POP with mem_ready held low: 15 wait cycles
      rst_n = 1'b1;
      drive(1'b1, 8'h74, 1'b0, 1'b0);
      cyc("pop_accept", E(1, 0, 0, 0, 0, 0, 0, 0, 0));
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++)
         cyc($sformatf("pop_wait%0d", i), E(0, 0, 1, 1, 0, 0, 1, 0, 0));
`ifdef MEM_TIMEOUT_EN
      cyc("pop_timeout", E(1, 0, 0, 0, 0, 0, 0, 1, 0));
      cyc("pop_after_timeout", E(1, 0, 0, 0, 0, 0, 0, 0, 0));
`else
      cyc("pop_unbounded", E(0, 0, 1, 1, 0, 0, 1, 0, 0));
      bus.mem_ready = 1'b1;
      cyc("pop_late_ready", E(0, 0, 1, 1, 0, 0, 1, 0, 0));
      bus.mem_ready = 1'b0;
      cyc("pop_late_done", E(0, 0, 0, 1, 1, 0, 1, 0, 0));
      cyc("pop_late_idle", E(1, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

      // mem_ready on the 15th wait cycle completes normally
      drive(1'b1, 8'h74, 1'b0, 1'b0);
      cyc("edge_accept", E(1, 0, 0, 0, 0, 0, 0, 0, 0));
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++)
         cyc($sformatf("edge_wait%0d", i), E(0, 0, 1, 1, 0, 0, 1, 0, 0));
      bus.mem_ready = 1'b1;
      cyc("edge_ready", E(0, 0, 1, 1, 0, 0, 1, 0, 0));
      bus.mem_ready = 1'b0;
      cyc("edge_done", E(0, 0, 0, 1, 1, 0, 1, 0, 0));
      cyc("edge_idle", E(1, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
